pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage CPU pipeline. Drives the per-stage
//  register enables (en) and bubble-inject requests for IF/ID, ID/EX, EX/MEM, MEM/WB.
//  Resolves load-use stalls, taken-branch flushes and data-memory wait states.
//  Keeps saturating performance counters. Sits beside the stage registers in CPU/Pipeline.
// PARAMETERS
//  LOAD_LAT    1     bubble cycles inserted per load-use hazard (1..7)
//  MEM_TIMEOUT 255   max MWAIT cycles before forced release (1..255)
//  CNT_W       16    width of the performance counters
// PORTS
//  clk          in   1      clock, all state updates on posedge
//  rst          in   1      synchronous reset, active-high
//  id_rs1       in   5      rs1 of instruction in ID
//  id_rs2       in   5      rs2 of instruction in ID
//  id_use_rs1   in   1      ID instruction reads rs1
//  id_use_rs2   in   1      ID instruction reads rs2
//  ex_rd        in   5      destination reg of instruction in EX
//  ex_is_load   in   1      EX instruction is a load
//  br_taken     in   1      EX resolved a taken branch/jump this cycle
//  mem_req      in   1      MEM stage is accessing data memory this cycle
//  mem_ready    in   1      data memory completes the access this cycle
//  pc_en        out  1      PC register load enable
//  en_s1..en_s4 out  1 each stage register enables (IF/ID, ID/EX, EX/MEM, MEM/WB)
//  bub_s1       out  1      IF/ID loads a NOP instead of its inputs
//  bub_s2       out  1      ID/EX loads a NOP (op_data=0, rd=0)
//  mem_err      out  1      one-cycle pulse: MWAIT timed out
//  state        out  2      current FSM state (debug)
//  stall_cnt    out  CNT_W  cycles with pc_en=0, saturating
//  flush_cnt    out  CNT_W  taken-branch flushes, saturating
// BEHAVIOUR
//  States: RUN=0, LSTALL=1, MWAIT=2, FLUSH=3. State and counters registered. Enables
//   and bubbles are combinational from state + inputs, so a hazard acts the same cycle.
//  Reset (rst=1 at posedge): state=RUN, counters=0, internal wait/lat counters=0.
//   While rst=1, outputs are forced: pc_en=0, en_s1..4=0, bub_s1=bub_s2=1, mem_err=0.
//   Reset mid-MWAIT/LSTALL aborts with no mem_err pulse.
//  hazard = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  memwait = mem_req & ~mem_ready. Priority in all states: memwait > br_taken > hazard.
//  RUN, default: all en=1, bub=0.
//   memwait: all en=0, pc_en=0 (full freeze). Next state MWAIT, wait_ctr=1.
//   br_taken: pc_en=1, all en=1, bub_s1=1, bub_s2=1. Next state FLUSH, flush_cnt++.
//   hazard: pc_en=0, en_s1=0, en_s2=1 with bub_s2=1, en_s3=en_s4=1.
//    Next state LSTALL if LOAD_LAT>1 (lat_ctr=1), else stays RUN.
//  LSTALL: same outputs as hazard case. lat_ctr++. Return to RUN when lat_ctr==LOAD_LAT-1.
//  MWAIT: full freeze while mem_ready=0, wait_ctr++.
//   On mem_ready=1: all en=1, pc_en=1, return to RUN.
//   On wait_ctr==MEM_TIMEOUT with mem_ready=0: mem_err=1, all en=1, return to RUN.
//  FLUSH (sync IMEM refetch): pc_en=1, all en=1, bub_s1=1. Next RUN.
//   memwait in FLUSH: freeze, go MWAIT; FLUSH is not resumed after MWAIT.
//  mem_ready=1 with mem_req=0 is ignored.
//  br_taken during a freeze is ignored; EX is held, so it is re-seen when the freeze releases.
//  Counters saturate at 2^CNT_W-1 and never wrap. stall_cnt counts every cycle with
//   pc_en=0 and rst=0.
// TESTING
//  T1 load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1, LOAD_LAT=1
//     -> one cycle: pc_en=0, en_s1=0, bub_s2=1. Next cycle RUN, all en=1; stall_cnt=1.
//  T2 x0 / unused operand: ex_rd=0 (or id_use_rs1=0) with matching rs -> no stall, all en=1.
//  T3 branch: br_taken=1 in RUN -> bub_s1=bub_s2=1, flush_cnt=1. Next cycle state=FLUSH,
//     bub_s1=1. Then RUN.
//  T4 mem wait: mem_req=1, mem_ready=0 for 3 cycles, then ready -> 3 frozen cycles
//     (all en=0), release on the ready cycle. stall_cnt=3. Same-cycle br_taken=1 is deferred.
//  T5 timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_err pulses exactly once,
//     then RUN with all en=1.
//  T6 reset: assert rst in MWAIT and LSTALL -> next cycle state=RUN, counters=0,
//     no mem_err. Counter saturation tested with CNT_W=4: 20 stalls -> stall_cnt=15.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs from ID/EX/MEM and enable/bubble/counter outputs of the pipeline controller.
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] i_id_rs1, i_id_rs2, i_ex_rd;
  logic i_id_use_rs1, i_id_use_rs2, i_ex_is_load, i_br_taken, i_mem_req, i_mem_ready;
  logic o_pc_en, o_en_s1, o_en_s2, o_en_s3, o_en_s4, o_bub_s1, o_bub_s2, o_mem_err;
  logic [1:0] o_state;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;
  modport master (
    output i_id_rs1, i_id_rs2, i_ex_rd, i_id_use_rs1, i_id_use_rs2, i_ex_is_load,
    output i_br_taken, i_mem_req, i_mem_ready,
    input o_pc_en, o_en_s1, o_en_s2, o_en_s3, o_en_s4, o_bub_s1, o_bub_s2, o_mem_err,
    input o_state, o_stall_cnt, o_flush_cnt
  );
  modport slave (
    input i_id_rs1, i_id_rs2, i_ex_rd, i_id_use_rs1, i_id_use_rs2, i_ex_is_load,
    input i_br_taken, i_mem_req, i_mem_ready,
    output o_pc_en, o_en_s1, o_en_s2, o_en_s3, o_en_s4, o_bub_s1, o_bub_s2, o_mem_err,
    output o_state, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline hazard controller (load-use stall, branch flush, memory wait) with saturating counters.
module pipeline_ctrl #(
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic rst,
  pipeline_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, LSTALL = 2'd1, MWAIT = 2'd2, FLUSH = 2'd3} state_t;
  state_t r_state, w_nxt;
  logic [2:0] r_lat, w_lat_n;
  logic [7:0] r_wait, w_wait_n;
  logic [CNT_W-1:0] r_stall, r_flush;
  logic w_hazard, w_memwait, w_run, w_pc_en, w_bub1, w_bub2, w_err, w_flush_inc;
  logic [3:0] w_en;
  assign w_memwait = bus.i_mem_req && !bus.i_mem_ready;
  assign w_hazard = bus.i_ex_is_load && bus.i_ex_rd != 5'd0 &&
                    ((bus.i_id_use_rs1 && bus.i_id_rs1 == bus.i_ex_rd) ||
                     (bus.i_id_use_rs2 && bus.i_id_rs2 == bus.i_ex_rd));
  // w_run: this cycle resolves hazards exactly as in RUN (also on MWAIT release, so a held branch is re-seen)
  always_comb begin
    w_pc_en = 1'b1;
    w_en = 4'hf;
    w_bub1 = 1'b0;
    w_bub2 = 1'b0;
    w_err = 1'b0;
    w_flush_inc = 1'b0;
    w_nxt = r_state;
    w_lat_n = r_lat;
    w_wait_n = r_wait;
    w_run = 1'b0;
    case (r_state)
      RUN: w_run = 1'b1;
      LSTALL: begin
        w_run = w_memwait || bus.i_br_taken;
        w_pc_en = w_run;
        w_en[0] = w_run;
        w_bub2 = !w_run;
        w_lat_n = r_lat + 3'd1;
        w_nxt = (r_lat == 3'(LOAD_LAT - 1)) ? RUN : LSTALL;
      end
      MWAIT: begin
        w_run = bus.i_mem_ready;
        w_err = !bus.i_mem_ready && r_wait == 8'(MEM_TIMEOUT);
        w_pc_en = bus.i_mem_ready || w_err;
        w_en = w_pc_en ? 4'hf : 4'h0;
        w_wait_n = r_wait + 8'd1;
        w_nxt = w_err ? RUN : MWAIT;
      end
      FLUSH: begin
        w_run = w_memwait;
        w_bub1 = 1'b1;
        w_nxt = RUN;
      end
      default: w_nxt = RUN;
    endcase
    if (w_run) begin
      w_pc_en = !(w_memwait || (!bus.i_br_taken && w_hazard));
      w_en = w_memwait ? 4'h0 : (!bus.i_br_taken && w_hazard) ? 4'he : 4'hf;
      w_bub1 = !w_memwait && bus.i_br_taken;
      w_bub2 = !w_memwait && (bus.i_br_taken || w_hazard);
      w_flush_inc = !w_memwait && bus.i_br_taken;
      w_wait_n = 8'd1;
      w_lat_n = 3'd1;
      w_nxt = w_memwait ? MWAIT : bus.i_br_taken ? FLUSH :
              (w_hazard && LOAD_LAT > 1) ? LSTALL : RUN;
    end
    if (rst) begin
      w_pc_en = 1'b0;
      w_en = 4'h0;
      w_bub1 = 1'b1;
      w_bub2 = 1'b1;
      w_err = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_lat <= '0;
      r_wait <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_state <= w_nxt;
      r_lat <= w_lat_n;
      r_wait <= w_wait_n;
      if (!w_pc_en && r_stall != '1) r_stall <= r_stall + 1'b1;
      if (w_flush_inc && r_flush != '1) r_flush <= r_flush + 1'b1;
    end
  end
  assign bus.o_pc_en = w_pc_en;
  assign {bus.o_en_s4, bus.o_en_s3, bus.o_en_s2, bus.o_en_s1} = w_en;
  assign bus.o_bub_s1 = w_bub1;
  assign bus.o_bub_s2 = w_bub2;
  assign bus.o_mem_err = w_err;
  assign bus.o_state = r_state;
  assign bus.o_stall_cnt = r_stall;
  assign bus.o_flush_cnt = r_flush;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors with a per-cycle expected-output scoreboard for two parameterisations.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipeline_ctrl_if #(.CNT_W(4)) if0 ();
  pipeline_ctrl_if #(.CNT_W(16)) if1 ();
  pipeline_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(4), .CNT_W(4)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  pipeline_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(255), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  typedef struct {
    string nm;
    bit sel;
    logic [9:0] o;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  // expected outputs {pc_en, en_s4..en_s1, bub_s1, bub_s2, mem_err, state}
  task automatic step(input string nm, input bit sel, input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic [4:0] rd, input logic ld, input logic br, input logic mq, input logic mr,
                      input logic pc, input logic [3:0] en, input logic b1, input logic b2, input logic er,
                      input logic [1:0] st, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    if0.i_id_rs1 = sel ? 5'd0 : rs1;
    if0.i_id_rs2 = sel ? 5'd0 : rs2;
    if0.i_id_use_rs1 = sel ? 1'b0 : u1;
    if0.i_id_use_rs2 = sel ? 1'b0 : u2;
    if0.i_ex_rd = sel ? 5'd0 : rd;
    if0.i_ex_is_load = sel ? 1'b0 : ld;
    if0.i_br_taken = sel ? 1'b0 : br;
    if0.i_mem_req = sel ? 1'b0 : mq;
    if0.i_mem_ready = sel ? 1'b0 : mr;
    if1.i_id_rs1 = sel ? rs1 : 5'd0;
    if1.i_id_rs2 = sel ? rs2 : 5'd0;
    if1.i_id_use_rs1 = sel ? u1 : 1'b0;
    if1.i_id_use_rs2 = sel ? u2 : 1'b0;
    if1.i_ex_rd = sel ? rd : 5'd0;
    if1.i_ex_is_load = sel ? ld : 1'b0;
    if1.i_br_taken = sel ? br : 1'b0;
    if1.i_mem_req = sel ? mq : 1'b0;
    if1.i_mem_ready = sel ? mr : 1'b0;
    e.nm = nm;
    e.sel = sel;
    e.o = {pc, en, b1, b2, er, st};
    e.sc = sc;
    e.fc = fc;
    q.push_back(e);
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [9:0] a;
    logic [31:0] asc, afc;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = e.sel ? {if1.o_pc_en, if1.o_en_s4, if1.o_en_s3, if1.o_en_s2, if1.o_en_s1,
                   if1.o_bub_s1, if1.o_bub_s2, if1.o_mem_err, if1.o_state}
                : {if0.o_pc_en, if0.o_en_s4, if0.o_en_s3, if0.o_en_s2, if0.o_en_s1,
                   if0.o_bub_s1, if0.o_bub_s2, if0.o_mem_err, if0.o_state};
      asc = e.sel ? 32'(if1.o_stall_cnt) : 32'(if0.o_stall_cnt);
      afc = e.sel ? 32'(if1.o_flush_cnt) : 32'(if0.o_flush_cnt);
      tests++;
      if (a !== e.o || asc !== e.sc || afc !== e.fc) begin
        fails++;
        $display("FAIL %s: got out=%b stall=%0d flush=%0d, expected out=%b stall=%0d flush=%0d",
                 e.nm, a, asc, afc, e.o, e.sc, e.fc);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    {if0.i_id_rs1, if0.i_id_rs2, if0.i_id_use_rs1, if0.i_id_use_rs2, if0.i_ex_rd} = '0;
    {if0.i_ex_is_load, if0.i_br_taken, if0.i_mem_req, if0.i_mem_ready} = '0;
    {if1.i_id_rs1, if1.i_id_rs2, if1.i_id_use_rs1, if1.i_id_use_rs2, if1.i_ex_rd} = '0;
    {if1.i_ex_is_load, if1.i_br_taken, if1.i_mem_req, if1.i_mem_ready} = '0;
    // DUT u0: LOAD_LAT=1, MEM_TIMEOUT=4, CNT_W=4
    step("rst",          0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 4'h0, 1, 1, 0, 2'd0, 0, 0);
    step("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'hf, 0, 0, 0, 2'd0, 0, 0);
    step("T1 hazard",    0, 0, 5, 0, 1, 0, 5, 1, 0, 0, 0,  0, 4'he, 0, 1, 0, 2'd0, 0, 0);
    step("T1 next",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'hf, 0, 0, 0, 2'd0, 1, 0);
    step("T2 x0",        0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0,  1, 4'hf, 0, 0, 0, 2'd0, 1, 0);
    step("T2 unused",    0, 0, 7, 3, 0, 1, 7, 1, 0, 0, 0,  1, 4'hf, 0, 0, 0, 2'd0, 1, 0);
    step("T1 rs2",       0, 0, 0, 9, 0, 1, 9, 1, 0, 0, 0,  0, 4'he, 0, 1, 0, 2'd0, 1, 0);
    step("T3 branch",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 4'hf, 1, 1, 0, 2'd0, 2, 0);
    step("T3 flush",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'hf, 1, 0, 0, 2'd3, 2, 1);
    step("T3 run",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'hf, 0, 0, 0, 2'd0, 2, 1);
    step("T4 freeze0",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 4'h0, 0, 0, 0, 2'd0, 2, 1);
    step("T4 freeze1",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 4'h0, 0, 0, 0, 2'd2, 3, 1);
    step("T4 freeze2",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 4'h0, 0, 0, 0, 2'd2, 4, 1);
    step("T4 release",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1,  1, 4'hf, 1, 1, 0, 2'd2, 5, 1);
    step("T4 flush",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'hf, 1, 0, 0, 2'd3, 5, 2);
    step("T5 wait0",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 4'h0, 0, 0, 0, 2'd0, 5, 2);
    step("T5 wait1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 4'h0, 0, 0, 0, 2'd2, 6, 2);
    step("T5 wait2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 4'h0, 0, 0, 0, 2'd2, 7, 2);
    step("T5 wait3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 4'h0, 0, 0, 0, 2'd2, 8, 2);
    step("T5 timeout",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 4'hf, 0, 0, 1, 2'd2, 9, 2);
    step("T5 after",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'hf, 0, 0, 0, 2'd0, 9, 2);
    step("ready no req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 4'hf, 0, 0, 0, 2'd0, 9, 2);
    step("prio mw>hz",   0, 0, 5, 0, 1, 0, 5, 1, 0, 1, 0,  0, 4'h0, 0, 0, 0, 2'd0, 9, 2);
    step("T6 rst mwait", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 4'h0, 1, 1, 0, 2'd2, 10, 2);
    step("T6 post",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'hf, 0, 0, 0, 2'd0, 0, 0);
    for (int i = 0; i < 20; i++)
      step("sat stall",  0, 0, 5, 0, 1, 0, 5, 1, 0, 0, 0,  0, 4'he, 0, 1, 0, 2'd0, (i > 15) ? 15 : i, 0);
    step("sat hold",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'hf, 0, 0, 0, 2'd0, 15, 0);
    step("prio br>hz",   0, 0, 5, 0, 1, 0, 5, 1, 1, 0, 0,  1, 4'hf, 1, 1, 0, 2'd0, 15, 0);
    step("flush2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'hf, 1, 0, 0, 2'd3, 15, 1);
    step("run2",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'hf, 0, 0, 0, 2'd0, 15, 1);
    // DUT u1: LOAD_LAT=3 exercises LSTALL
    step("L rst",        1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 4'h0, 1, 1, 0, 2'd0, 0, 0);
    step("L hazard",     1, 0, 4, 0, 1, 0, 4, 1, 0, 0, 0,  0, 4'he, 0, 1, 0, 2'd0, 0, 0);
    step("L bubble1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 4'he, 0, 1, 0, 2'd1, 1, 0);
    step("L bubble2",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 4'he, 0, 1, 0, 2'd1, 2, 0);
    step("L run",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'hf, 0, 0, 0, 2'd0, 3, 0);
    step("L hazard2",    1, 0, 0, 6, 0, 1, 6, 1, 0, 0, 0,  0, 4'he, 0, 1, 0, 2'd0, 3, 0);
    step("L rst lstall", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 4'h0, 1, 1, 0, 2'd1, 4, 0);
    step("L post",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 4'hf, 0, 0, 0, 2'd0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries never checked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
